// File: rtl/vae_buf_pkg.sv
// Shared types and defaults for the VAE forward input buffer path.
// Holds the stream loader state encoding and buffer geometry.
package vae_buf_pkg;

  localparam int MEM_DEPTH  = 21;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 64;
  localparam int BEAT_W     = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } ld_state_e;

endpackage

// File: rtl/dma_stream_loader.sv
// AXI-Stream to input-buffer write strobes, with frame length checking.
// Build option LOADER_CHECKSUM_EN adds an XOR checksum of written beats.
module dma_stream_loader
  import vae_buf_pkg::*;
#(
  parameter int MEM_DEPTH  = vae_buf_pkg::MEM_DEPTH,
  parameter int ADDR_WIDTH = vae_buf_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = vae_buf_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [DATA_WIDTH-1:0] frame_xor
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(MEM_DEPTH - 1);

  ld_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  tready_q, tready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] xor_q, xor_d;
  logic                  acc;

  assign acc = s_axis_tvalid && tready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tready_d  = tready_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    xor_d     = xor_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d  = ST_LOAD;
          cnt_d    = '0;
          err_d    = 1'b0;
          xor_d    = '0;
          tready_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (acc) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = s_axis_tdata;
          xor_d     = xor_q ^ s_axis_tdata;
          if (s_axis_tlast) begin
            tready_d = 1'b0;
            busy_d   = 1'b0;
            if (cnt_q == LAST_IDX) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end
          end else if (cnt_q == LAST_IDX) begin
            // overlong: keep draining so the DMA never stalls
            state_d = ST_DRAIN;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (acc && s_axis_tlast) begin
          state_d  = ST_IDLE;
          tready_d = 1'b0;
          busy_d   = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        tready_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tready_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tready_q  <= tready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) xor_q <= '0;
    else        xor_q <= xor_d;
  end
  assign frame_xor = xor_q;
`else
  assign xor_q     = '0;
  assign frame_xor = '0;
`endif

  assign s_axis_tready = tready_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_err     = err_q;

endmodule
